// File: rtl/next_pc_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) and branch
// resolution from execute; a mispredict redirects fetch the following cycle.
module next_pc_unit #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pred_pc,
  input  logic            ex_valid,
  input  logic [2:0]      ex_branch,
  input  logic            ex_zero,
  input  logic            ex_result0,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_busa,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pred_pc,
  output logic            flush
);
  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  logic            btb_valid  [BTB_DEPTH];
  logic [TAGW-1:0] btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0] btb_target [BTB_DEPTH];
  logic [1:0]      btb_cnt    [BTB_DEPTH];

  // Fetch-side lookup always sees the pre-update contents of the table.
  logic [IDXW-1:0] f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;

  assign f_idx   = pc[IDXW+1:2];
  assign f_tag   = pc[XLEN-1:IDXW+2];
  assign f_hit   = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pred_pc = (f_hit && btb_cnt[f_idx][1]) ? btb_target[f_idx] : pc + XLEN'(4);

  // ex_valid qualifies every resolution input; with it low nothing from
  // execute can redirect fetch or touch the table.
  logic            is_br;
  logic            taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] actual_next;
  logic [IDXW-1:0] e_idx;
  logic [TAGW-1:0] e_tag;
  logic            e_hit;

  always_comb begin
    is_br = 1'b1;
    taken = 1'b0;
    unique case (ex_branch)
      BR_JAL, BR_JALR: taken = 1'b1;
      BR_BEQ:          taken = ex_zero;
      BR_BNE:          taken = !ex_zero;
      BR_BLT:          taken = ex_result0;
      BR_BGE:          taken = !ex_result0;
      default:         is_br = 1'b0;
    endcase
  end

  assign jalr_sum    = ex_busa + ex_imm;
  assign br_target   = (ex_branch == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
  assign actual_next = taken ? br_target : ex_pc + XLEN'(4);
  assign flush       = ex_valid && (actual_next != ex_pred_pc);

  assign e_idx = ex_pc[IDXW+1:2];
  assign e_tag = ex_pc[XLEN-1:IDXW+2];
  assign e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cnt[i]   <= 2'b01;
      end
    end else begin
      if (flush)       pc <= actual_next;
      else if (!stall) pc <= pred_pc;

      // Training is independent of stall: execute retires regardless of fetch.
      if (ex_valid && is_br) begin
        if (taken) begin
          btb_target[e_idx] <= br_target;
          if (e_hit) begin
            if (btb_cnt[e_idx] != 2'b11) btb_cnt[e_idx] <= btb_cnt[e_idx] + 2'b01;
          end else begin
            btb_valid[e_idx] <= 1'b1;
            btb_tag[e_idx]   <= e_tag;
            btb_cnt[e_idx]   <= 2'b10;
          end
        end else if (e_hit && btb_cnt[e_idx] != 2'b00) begin
          btb_cnt[e_idx] <= btb_cnt[e_idx] - 2'b01;
        end
      end
    end
  end
endmodule
